// File: rtl/memory_pkg.sv
// Shared encodings for the RV32 memory stage: access sizes, writeback selects,
// exception causes, FSM states and the registered bus request.
package memory_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    WS_ALU  = 2'b00,
    WS_LOAD = 2'b01,
    WS_CSR  = 2'b10,
    WS_PC4  = 2'b11
  } wsel_e;

  localparam logic [3:0] ECAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] ECAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] ECAUSE_STORE_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_req_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_HALF: lane_be = 4'b0011 << lane;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_load_align.sv
// Load data alignment: picks the addressed byte/half out of the raw bus word
// and sign- or zero-extends it. Words pass through unchanged.
module mem_load_align
  import memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{lane, 3'b000} +: 8];
    h    = lane[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{sgn & b[7]}}, b};
      SZ_HALF: data = {{16{sgn & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory.sv
// RV32 memory stage: one bus request per load/store, load alignment, branch
// redirect and writeback registers. MEMORY_MISALIGNED_TRAP_EN traps misaligned accesses.
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] alu_addition_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        cmp_output_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  load_store_size_in,
  input  logic        load_signed_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_address_out,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  mem_state_e  state;
  mem_req_t    req;
  logic [1:0]  ld_lane;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [31:0] ld_buf;
  logic [31:0] ld_aligned;
  logic        kill;

  logic        is_ls, misaligned, access, hold, mis_exc;
  logic [1:0]  lane_raw, lane;
  logic [31:0] wdata;

  assign is_ls    = load_in || store_in;
  assign lane_raw = alu_addition_in[1:0];

  // Lane is always truncated to size alignment; the trap build never issues
  // the truncated access because misaligned blocks the request.
  always_comb begin
    case (load_store_size_in)
      SZ_BYTE: lane = lane_raw;
      SZ_HALF: lane = {lane_raw[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

`ifdef MEMORY_MISALIGNED_TRAP_EN
  assign misaligned = is_ls &&
    ((load_store_size_in == SZ_HALF && lane_raw[0]) ||
     (load_store_size_in == SZ_WORD && lane_raw != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (load_store_size_in)
      SZ_BYTE: wdata = {4{rs2_data_in[7:0]}};
      SZ_HALF: wdata = {2{rs2_data_in[15:0]}};
      default: wdata = rs2_data_in;
    endcase
  end

  assign access   = valid_in && is_ls && !exception_in && !misaligned && !invalidate;
  assign busy_out = (state == ST_IDLE && access) || state == ST_WAIT;
  assign hold     = stall || busy_out;
  assign mis_exc  = valid_in && misaligned;

  assign branch_taken_out   = valid_in && !exception_in && (jump_in || (branch_in && cmp_output_in));
  assign branch_address_out = alu_addition_in;

  assign mem_we      = req.we;
  assign mem_address = req.addr;
  assign mem_byte_en = req.be;
  assign mem_wdata   = req.wdata;

  mem_load_align u_align (
    .rdata (mem_rdata),
    .lane  (ld_lane),
    .size  (ld_size),
    .sgn   (ld_signed),
    .data  (ld_aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      req              <= '0;
      mem_req          <= 1'b0;
      ld_lane          <= 2'b00;
      ld_size          <= 2'b00;
      ld_signed        <= 1'b0;
      ld_buf           <= '0;
      kill             <= 1'b0;
      pc_out           <= '0;
      next_pc_out      <= '0;
      alu_data_out     <= '0;
      csr_data_out     <= '0;
      load_data_out    <= '0;
      write_select_out <= '0;
      rd_address_out   <= '0;
      csr_address_out  <= '0;
      csr_write_out    <= 1'b0;
      mret_out         <= 1'b0;
      wfi_out          <= 1'b0;
      valid_out        <= 1'b0;
      exception_out    <= 1'b0;
      ecause_out       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (access) begin
          req       <= '{addr:  {alu_addition_in[31:2], 2'b00},
                         be:    lane_be(load_store_size_in, lane),
                         wdata: wdata,
                         we:    store_in};
          mem_req   <= 1'b1;
          ld_lane   <= lane;
          ld_size   <= load_store_size_in;
          ld_signed <= load_signed_in;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // The bus transfer is never aborted; an invalidate only discards it.
          if (invalidate) kill <= 1'b1;
          if (mem_ready) begin
            ld_buf  <= ld_aligned;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: if (!stall) begin
          kill  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (!hold) begin
        pc_out           <= pc_in;
        next_pc_out      <= next_pc_in;
        alu_data_out     <= alu_data_in;
        csr_data_out     <= csr_data_in;
        load_data_out    <= (state == ST_DONE) ? ld_buf : '0;
        write_select_out <= write_select_in;
        rd_address_out   <= rd_address_in;
        csr_address_out  <= csr_address_in;
        csr_write_out    <= csr_write_in;
        mret_out         <= mret_in;
        wfi_out          <= wfi_in;
        valid_out        <= valid_in && !invalidate && !kill;
        exception_out    <= exception_in || mis_exc;
        ecause_out       <= exception_in ? ecause_in :
                            mis_exc ? (load_in ? ECAUSE_LOAD_MISALIGN : ECAUSE_STORE_MISALIGN) :
                            4'd0;
      end else begin
        valid_out <= valid_out && !invalidate;
      end
    end
  end

endmodule
